// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: groups received bytes into frames closed by an idle timeout
// and queues per-frame info {ByteCnt, ms stamp, 0.1 ms stamp} in a 4-entry
// first-word-fall-through queue.
// Optional feature macro: RX_FRAME_TIMESTAMP_EN (stamp capture; when undefined
// FrameInfo_o[15:0] reads 0 and no stamp registers exist).
module rx_frame_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        p_Enable_i,
    input  logic        p_FrameFunctionEnable_i,
    input  logic        BaudSig_i,
    input  logic        p_ByteWritten_i,
    input  logic [15:0] RxTimeOutSet_i,
    input  logic [11:0] millisecond_stamp_i,
    input  logic [3:0]  acqurate_stamp_i,
    input  logic        n_RxFrameInfo_Rd_i,
    output logic [27:0] FrameInfo_o,
    output logic        p_RxFrame_Empty_o,
    output logic        p_RxFrame_Full_o,
    output logic [2:0]  FrameLevel_o,
    output logic        p_RxTimeOut_o,
    output logic        p_FrameOver_o
);

    localparam logic [2:0] ST_IDLE   = 3'b001;
    localparam logic [2:0] ST_RECV   = 3'b010;
    localparam logic [2:0] ST_COMMIT = 3'b100;

    logic [2:0]  state_q, state_d;
    logic [11:0] byte_cnt_q, byte_cnt_d;
    logic [15:0] idle_cnt_q, idle_cnt_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  level_q, level_d;
    logic        over_q, over_d;
    logic [27:0] fifo_q [4];
    logic [27:0] fifo_d [4];

    logic        active;
    logic        start_frame;
    logic [15:0] timeout_thr;
    logic [16:0] idle_inc;
    logic        q_empty;
    logic        q_full;
    logic        pop_ok;
    logic        push_req;
    logic        push_ok;
    logic [27:0] entry;

`ifdef RX_FRAME_TIMESTAMP_EN
    logic [15:0] stamp_q, stamp_d;
    assign entry = {byte_cnt_q, stamp_q};
`else
    logic [15:0] unused_stamps;
    assign unused_stamps = {millisecond_stamp_i, acqurate_stamp_i};
    assign entry = {byte_cnt_q, 16'h0000};
`endif

    assign active      = p_Enable_i & p_FrameFunctionEnable_i;
    assign timeout_thr = (RxTimeOutSet_i == '0) ? 16'd1 : RxTimeOutSet_i;
    assign idle_inc    = {1'b0, idle_cnt_q} + 17'd1;

    // Frame delimiting FSM: counts bytes, measures idle time, closes frames
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        start_frame = 1'b0;
`ifdef RX_FRAME_TIMESTAMP_EN
        stamp_d     = stamp_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (active && p_ByteWritten_i) start_frame = 1'b1;
            end
            ST_RECV: begin
                if (!active) begin
                    state_d    = ST_IDLE;
                    byte_cnt_d = '0;
                    idle_cnt_d = '0;
                end else if (p_ByteWritten_i) begin
                    if (byte_cnt_q != 12'hFFF) byte_cnt_d = byte_cnt_q + 12'd1;
                    idle_cnt_d = '0;
`ifdef RX_FRAME_TIMESTAMP_EN
                    stamp_d = {millisecond_stamp_i, acqurate_stamp_i};
`endif
                end else if (BaudSig_i) begin
                    idle_cnt_d = idle_inc[15:0];
                    if (idle_inc >= {1'b0, timeout_thr}) state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                // A byte landing in the commit cycle opens the next frame at once
                if (active && p_ByteWritten_i) begin
                    start_frame = 1'b1;
                end else begin
                    state_d    = ST_IDLE;
                    byte_cnt_d = '0;
                    idle_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                byte_cnt_d = '0;
                idle_cnt_d = '0;
            end
        endcase
        if (start_frame) begin
            state_d    = ST_RECV;
            byte_cnt_d = 12'd1;
            idle_cnt_d = '0;
`ifdef RX_FRAME_TIMESTAMP_EN
            stamp_d = {millisecond_stamp_i, acqurate_stamp_i};
`endif
        end
    end

    assign q_empty  = (level_q == 3'd0);
    assign q_full   = (level_q == 3'd4);
    assign pop_ok   = !n_RxFrameInfo_Rd_i && !q_empty;
    assign push_req = (state_q == ST_COMMIT);
    assign push_ok  = push_req && (!q_full || pop_ok);

    // Frame-info queue: push on commit, pop on request, overflow flag
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        over_d   = over_q;
        if (push_ok) begin
            fifo_d[wr_ptr_q] = entry;
            wr_ptr_d         = wr_ptr_q + 2'd1;
        end
        if (pop_ok) rd_ptr_d = rd_ptr_q + 2'd1;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 3'd1;
            2'b01:   level_d = level_q - 3'd1;
            default: level_d = level_q;
        endcase
        if (push_req && !push_ok) over_d = 1'b1;
        else if (pop_ok)          over_d = 1'b0;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= '0;
            idle_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            over_q     <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) fifo_q[i] <= '0;
`ifdef RX_FRAME_TIMESTAMP_EN
            stamp_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            over_q     <= over_d;
            fifo_q     <= fifo_d;
`ifdef RX_FRAME_TIMESTAMP_EN
            stamp_q    <= stamp_d;
`endif
        end
    end

    assign FrameInfo_o       = q_empty ? '0 : fifo_q[rd_ptr_q];
    assign p_RxFrame_Empty_o = q_empty;
    assign p_RxFrame_Full_o  = q_full;
    assign FrameLevel_o      = level_q;
    assign p_RxTimeOut_o     = (state_q == ST_COMMIT);
    assign p_FrameOver_o     = over_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Testbench for rx_frame_ctrl: table-driven frame, directed corner sequences
// and randomized traffic against a frame/queue-level reference model.
module tb_rx_frame_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        en = 1'b1, ffe = 1'b1, baud = 1'b0, byte_w = 1'b0, rd_n = 1'b1;
    logic [15:0] tmo = 16'd3;
    logic [11:0] ms = '0;
    logic [3:0]  acq = '0;
    logic [27:0] info;
    logic        empty, full, to, over;
    logic [2:0]  level;

    rx_frame_ctrl dut (
        .clk                     (clk),
        .rst                     (rst),
        .p_Enable_i              (en),
        .p_FrameFunctionEnable_i (ffe),
        .BaudSig_i               (baud),
        .p_ByteWritten_i         (byte_w),
        .RxTimeOutSet_i          (tmo),
        .millisecond_stamp_i     (ms),
        .acqurate_stamp_i        (acq),
        .n_RxFrameInfo_Rd_i      (rd_n),
        .FrameInfo_o             (info),
        .p_RxFrame_Empty_o       (empty),
        .p_RxFrame_Full_o        (full),
        .FrameLevel_o            (level),
        .p_RxTimeOut_o           (to),
        .p_FrameOver_o           (over)
    );

    int checks = 0;
    int errors = 0;
    int to_seen = 0;

    // Reference model: frame in progress plus a queue of finished frame records
    bit          m_in_frame = 0;
    bit          m_closing = 0;
    bit          m_over = 0;
    int          m_bytes = 0;
    int          m_idle = 0;
    logic [15:0] m_stamp = '0;
    logic [27:0] m_pending = '0;
    logic [27:0] m_q[$];

    function automatic logic [15:0] stamp_field(logic [11:0] a, logic [3:0] b);
`ifdef RX_FRAME_TIMESTAMP_EN
        return {a, b};
`else
        return 16'h0000;
`endif
    endfunction

    task automatic model_step();
        bit active;
        int thr;
        if (rst) begin
            m_in_frame = 0; m_closing = 0; m_over = 0;
            m_bytes = 0; m_idle = 0; m_q.delete();
            return;
        end
        active = en && ffe;
        thr = (tmo == 0) ? 1 : int'(tmo);
        if (!rd_n && m_q.size() > 0) begin
            void'(m_q.pop_front());
            m_over = 0;
        end
        if (m_closing) begin
            if (m_q.size() < 4) m_q.push_back(m_pending);
            else m_over = 1;
        end
        m_closing = 0;
        if (!active) begin
            m_in_frame = 0;
        end else if (!m_in_frame) begin
            if (byte_w) begin
                m_in_frame = 1; m_bytes = 1; m_idle = 0;
                m_stamp = stamp_field(ms, acq);
            end
        end else if (byte_w) begin
            m_bytes = (m_bytes < 4095) ? m_bytes + 1 : 4095;
            m_idle = 0;
            m_stamp = stamp_field(ms, acq);
        end else if (baud) begin
            m_idle++;
            if (m_idle >= thr) begin
                m_pending = {12'(m_bytes), m_stamp};
                m_closing = 1;
                m_in_frame = 0;
            end
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: apply inputs, advance the model, compare everything after the edge
    task automatic cyc(input logic b, input logic bd, input logic rdn);
        logic [27:0] exp_info;
        byte_w = b; baud = bd; rd_n = rdn;
        ms  = 12'($urandom_range(0, 999));
        acq = 4'($urandom_range(0, 9));
        model_step();
        @(posedge clk);
        #1;
        if (to) to_seen++;
        exp_info = (m_q.size() > 0) ? m_q[0] : 28'h0;
        check("model", {info, level, empty, full, to, over},
              {exp_info, 3'(m_q.size()), m_q.size() == 0, m_q.size() == 4, m_closing, m_over});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b1);
        rst = 1'b0;
    endtask

    // n bytes, then bauds until the timeout commits, then the push cycle
    task automatic frame(input int n, input int gap);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < gap; i++) cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
    endtask

    typedef struct {
        string       name;
        logic        b, bd, rdn;
        logic [11:0] cnt;
        logic [2:0]  lvl;
        logic        emp, ful, to_e, ovr;
    } vec_t;

    vec_t tbl[9];

    function automatic vec_t mk(string nm, logic b, logic bd, logic [11:0] c,
                                logic [2:0] l, logic e, logic t);
        vec_t v;
        v.name = nm; v.b = b; v.bd = bd; v.rdn = 1'b1;
        v.cnt = c; v.lvl = l; v.emp = e; v.ful = 1'b0; v.to_e = t; v.ovr = 1'b0;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = mk("t_byte1", 1, 0, 12'd0, 3'd0, 1, 0);
        tbl[1] = mk("t_byte2", 1, 0, 12'd0, 3'd0, 1, 0);
        tbl[2] = mk("t_byte3", 1, 0, 12'd0, 3'd0, 1, 0);
        tbl[3] = mk("t_byte4", 1, 0, 12'd0, 3'd0, 1, 0);
        tbl[4] = mk("t_byte5", 1, 0, 12'd0, 3'd0, 1, 0);
        tbl[5] = mk("t_baud1", 0, 1, 12'd0, 3'd0, 1, 0);
        tbl[6] = mk("t_baud2", 0, 1, 12'd0, 3'd0, 1, 0);
        tbl[7] = mk("t_baud3", 0, 1, 12'd0, 3'd0, 1, 1);
        tbl[8] = mk("t_push",  0, 0, 12'd5, 3'd1, 0, 0);

        // Reset state
        do_reset();
        check("reset_outputs", {info, level, empty, full, to, over},
              {28'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0});

        // Timeout 3: five bytes then three baud ticks
        tmo = 16'd3;
        for (int i = 0; i < 9; i++) begin
            cyc(tbl[i].b, tbl[i].bd, tbl[i].rdn);
            check(tbl[i].name, {info[27:16], level, empty, full, to, over},
                  {tbl[i].cnt, tbl[i].lvl, tbl[i].emp, tbl[i].ful, tbl[i].to_e, tbl[i].ovr});
        end

        // Timeout 0 acts as 1; push coinciding with pop on empty
        do_reset();
        tmo = 16'd0;
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        check("tmo0_pulse", {31'd0, to}, 32'd1);
        cyc(1'b0, 1'b0, 1'b0);
        check("tmo0_head", {info[27:16], level}, {12'd1, 3'd1});

        // Fill queue, overflow, then pop
        do_reset();
        tmo = 16'd1;
        frame(2, 1); frame(3, 1); frame(4, 1); frame(5, 1);
        check("full_after4", {full, level}, {1'b1, 3'd4});
        frame(6, 1);
        check("overflow", {over, level, info[27:16]}, {1'b1, 3'd4, 12'd2});
        cyc(1'b0, 1'b0, 1'b0);
        check("pop_after_over", {over, level, info[27:16]}, {1'b0, 3'd3, 12'd3});

        // Byte arriving in the commit cycle starts the next frame
        do_reset();
        tmo = 16'd1;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        check("commit_pulse", {31'd0, to}, 32'd1);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        check("two_frames", {info[27:16], level}, {12'd3, 3'd2});
        cyc(1'b0, 1'b0, 1'b0);
        check("second_frame", {info[27:16], level}, {12'd1, 3'd1});

        // Byte count saturation
        do_reset();
        tmo = 16'd1;
        frame(4100, 1);
        check("saturate", {info[27:16], level}, {12'd4095, 3'd1});

        // Enable dropping mid-frame discards the frame silently
        do_reset();
        tmo = 16'd3;
        to_seen = 0;
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        en = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1);
        en = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1);
        check("abort_no_pulse", 64'(to_seen), 64'd0);
        check("abort_level", {level, empty}, {3'd0, 1'b1});
        cyc(1'b0, 1'b0, 1'b0);
        check("pop_empty", {level, empty}, {3'd0, 1'b1});

        // Randomized traffic checked every cycle by the model
        do_reset();
        for (int seg = 0; seg < 12; seg++) begin
            int bp, dp, rp;
            case ($urandom_range(0, 4))
                0: tmo = 16'd0;
                1: tmo = 16'd1;
                2: tmo = 16'd2;
                3: tmo = 16'd3;
                default: tmo = 16'd5;
            endcase
            bp = $urandom_range(10, 60);
            dp = $urandom_range(20, 70);
            rp = $urandom_range(5, 40);
            for (int c = 0; c < 250; c++) begin
                en  = ($urandom_range(0, 99) < 97);
                ffe = ($urandom_range(0, 99) < 98);
                rst = ($urandom_range(0, 499) == 0);
                cyc($urandom_range(0, 99) < bp, $urandom_range(0, 99) < dp,
                    !($urandom_range(0, 99) < rp));
            end
            rst = 1'b0; en = 1'b1; ffe = 1'b1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
